// File: rtl/ultrasonic_scheduler.sv
// HC-SR04 style measurement sequencer: trigger, echo timing, cm conversion.
// Publishes the rounded distance with a 1-cycle strobe; handles timeouts and shot period.
module ultrasonic_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int PERIOD_CYCLES  = 3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trigger,
    output logic [15:0] cm,
    output logic        cm_valid,
    output logic        timeout_err,
    output logic        busy
);

    localparam int GW = $clog2(TRIG_CYCLES + 1);
    localparam int SW = $clog2(CYCLES_PER_CM + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);

    localparam logic [GW-1:0] TRIG_LAST = GW'(TRIG_CYCLES - 1);
    localparam logic [SW-1:0] CPC_LAST  = SW'(CYCLES_PER_CM - 1);
    localparam logic [SW-1:0] CPC_HALF  = SW'(CYCLES_PER_CM / 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        CONVERT,
        HOLDOFF
    } state_t;

    state_t state;
    state_t state_n;

    logic echo_m;
    logic echo_s;
    logic echo_d;
    logic rise;
    logic fall;

    logic [GW-1:0] trig_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] per_cnt;
    logic [SW-1:0] sub_cnt;
    logic [15:0]   cm_acc;
    logic [15:0]   cm_round;

    logic trig_done;
    logic tmo_hit;
    logic per_done;
    logic set_valid;
    logic set_tmo;

    assign rise      = echo_s & ~echo_d;
    assign fall      = ~echo_s & echo_d;
    assign trig_done = (trig_cnt == TRIG_LAST);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign per_done  = (per_cnt == PER_LAST);
    assign busy      = (state != IDLE);

    // Round half up on the leftover sub-centimetre count, never wrapping past 16'hFFFF.
    assign cm_round = ((sub_cnt >= CPC_HALF) && (cm_acc != 16'hFFFF))
                    ? cm_acc + 16'd1 : cm_acc;

    // Two-flop synchroniser for the async echo pin plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and strobe requests.
    always_comb begin
        state_n   = state;
        set_valid = 1'b0;
        set_tmo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_n = TRIG;
            end
            TRIG: begin
                if (trig_done) state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_n = MEASURE;
                end else if (tmo_hit) begin
                    state_n = HOLDOFF;
                    set_tmo = 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_n = CONVERT;
                end else if (tmo_hit) begin
                    state_n = HOLDOFF;
                    set_tmo = 1'b1;
                end
            end
            CONVERT: begin
                set_valid = 1'b1;
                state_n   = HOLDOFF;
            end
            HOLDOFF: begin
                if (per_done) state_n = enable ? TRIG : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Trigger width, timeout and shot-period counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_cnt <= '0;
            tmo_cnt  <= '0;
            per_cnt  <= '0;
        end else begin
            if ((state == TRIG) && !trig_done) begin
                trig_cnt <= trig_cnt + 1'b1;
            end else begin
                trig_cnt <= '0;
            end

            if ((((state == WAIT_RISE) && !rise) || (state == MEASURE)) && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if ((state == IDLE) || ((state == HOLDOFF) && per_done)) begin
                per_cnt <= '0;
            end else if (!per_done) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

    // Echo width accumulation in whole centimetres plus a sub-centimetre remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_cnt <= '0;
            cm_acc  <= '0;
        end else if ((state == WAIT_RISE) && rise) begin
            sub_cnt <= '0;
            cm_acc  <= '0;
        end else if ((state == MEASURE) && echo_s) begin
            if (sub_cnt == CPC_LAST) begin
                sub_cnt <= '0;
                if (cm_acc != 16'hFFFF) cm_acc <= cm_acc + 16'd1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    // Registered outputs: trigger follows the TRIG state, strobes align with cm update.
    always_ff @(posedge clk) begin
        if (reset) begin
            trigger     <= 1'b0;
            cm          <= 16'd0;
            cm_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            trigger     <= (state_n == TRIG);
            cm_valid    <= set_valid;
            timeout_err <= set_tmo;
            if (set_valid) cm <= cm_round;
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing parameters.
// Covers trigger width, conversion rounding, timeouts, shot spacing, enable drop and reset.
module tb_ultrasonic_scheduler;

    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_VALID = 2;
    localparam int K_TMO   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        echo;
    logic        trigger;
    logic [15:0] cm;
    logic        cm_valid;
    logic        timeout_err;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    int cyc         = 0;
    int n_rise      = 0;
    int n_fall      = 0;
    int n_valid     = 0;
    int n_tmo       = 0;
    int n_both      = 0;
    int last_rise   = 0;
    int prev_rise   = 0;
    int last_fall   = 0;
    int last_tmo    = 0;
    int hi_len      = 0;
    int last_hi_len = 0;
    logic trig_q    = 1'b0;

    ultrasonic_scheduler #(
        .TRIG_CYCLES   (10),
        .CYCLES_PER_CM (29),
        .TIMEOUT_CYCLES(1000),
        .PERIOD_CYCLES (2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .echo       (echo),
        .trigger    (trigger),
        .cm         (cm),
        .cm_valid   (cm_valid),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (trigger && !trig_q) begin
            n_rise    = n_rise + 1;
            prev_rise = last_rise;
            last_rise = cyc;
            hi_len    = 0;
        end
        if (trigger) hi_len = hi_len + 1;
        if (!trigger && trig_q) begin
            n_fall      = n_fall + 1;
            last_fall   = cyc;
            last_hi_len = hi_len;
        end
        if (cm_valid) n_valid = n_valid + 1;
        if (timeout_err) begin
            n_tmo    = n_tmo + 1;
            last_tmo = cyc;
        end
        if (cm_valid && timeout_err) n_both = n_both + 1;
        trig_q = trigger;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int kind);
        case (kind)
            K_RISE:  return n_rise;
            K_FALL:  return n_fall;
            K_VALID: return n_valid;
            default: return n_tmo;
        endcase
    endfunction

    task automatic wait_cnt(input int kind, input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (cnt_of(kind) < target && k < budget) begin
            step();
            k = k + 1;
        end
        chk(tag, cnt_of(kind), target);
    endtask

    task automatic shot(input int dly, input int width);
        repeat (dly) step();
        echo = 1'b1;
        repeat (width) step();
        echo = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        echo   = 1'b0;
        repeat (5) step();
        chk("rst_trigger", trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cm", cm, 0);
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_no_strobes", n_valid + n_tmo, 0);

        reset = 1'b0;
        wait_cnt(K_RISE, 1, 20, "trig1_rise");
        chk("trig1_busy", busy, 1);
        wait_cnt(K_FALL, 1, 40, "trig1_fall");
        chk("trig1_width", last_hi_len, 10);

        shot(50, 290);
        wait_cnt(K_VALID, 1, 100, "shot1_valid");
        chk("shot1_cm", cm, 10);
        chk("shot1_no_tmo", n_tmo, 0);

        wait_cnt(K_RISE, 2, 2100, "trig2_rise");
        chk("period_1_2", last_rise - prev_rise, 2000);
        wait_cnt(K_FALL, 2, 40, "trig2_fall");
        shot(40, 304);
        wait_cnt(K_VALID, 2, 100, "shot2_valid");
        chk("shot2_cm_304", cm, 10);

        wait_cnt(K_RISE, 3, 2100, "trig3_rise");
        chk("period_2_3", last_rise - prev_rise, 2000);
        wait_cnt(K_FALL, 3, 40, "trig3_fall");
        shot(60, 305);
        wait_cnt(K_VALID, 3, 100, "shot3_valid");
        chk("shot3_cm_305", cm, 11);

        wait_cnt(K_RISE, 4, 2100, "trig4_rise");
        chk("period_3_4", last_rise - prev_rise, 2000);
        wait_cnt(K_FALL, 4, 40, "trig4_fall");
        wait_cnt(K_TMO, 1, 1100, "norise_tmo");
        chk("norise_tmo_delay", last_tmo - last_fall, 1000);
        chk("norise_cm_kept", cm, 11);
        chk("norise_no_valid", n_valid, 3);

        wait_cnt(K_RISE, 5, 2100, "trig5_rise");
        chk("period_4_5", last_rise - prev_rise, 2000);
        wait_cnt(K_FALL, 5, 40, "trig5_fall");
        shot(20, 1200);
        chk("stuck_tmo", n_tmo, 2);
        chk("stuck_no_valid", n_valid, 3);
        chk("stuck_cm_kept", cm, 11);
        wait_cnt(K_RISE, 6, 2100, "trig6_rise");
        chk("period_5_6", last_rise - prev_rise, 2000);

        wait_cnt(K_FALL, 6, 40, "trig6_fall");
        repeat (30) step();
        echo = 1'b1;
        repeat (100) step();
        enable = 1'b0;
        repeat (190) step();
        echo = 1'b0;
        wait_cnt(K_VALID, 4, 100, "endis_valid");
        chk("endis_cm", cm, 10);
        repeat (2500) step();
        chk("endis_no_trigger", n_rise, 6);
        chk("endis_idle", busy, 0);
        chk("endis_trigger_low", trigger, 0);

        enable = 1'b1;
        wait_cnt(K_RISE, 7, 20, "trig7_rise");
        wait_cnt(K_FALL, 7, 40, "trig7_fall");
        repeat (20) step();
        echo = 1'b1;
        repeat (100) step();
        reset = 1'b1;
        step();
        chk("midrst_trigger", trigger, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cm_valid", cm_valid, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        echo = 1'b0;
        repeat (3) step();
        chk("midrst_no_valid", n_valid, 4);
        chk("midrst_no_tmo", n_tmo, 2);
        chk("midrst_cm_cleared", cm, 0);
        chk("never_both_strobes", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
